// File: rtl/ppu_frame_loader.sv
// ppu_frame_loader: vblank-time attribute loader for the PPU.
// On each vblank rising edge it streams palette RAM, then OAM, into shadow
// registers that the line renderer reads through combinational query ports.
// A load cut short by vblank falling is reported on load_error.
// Optional build macro PPU_FRAME_LOADER_DOUBLE_BUFFER_EN: two banks, with
// the front bank swapped only on a complete load.
module ppu_frame_loader #(
  parameter int NUM_PALETTES = 8,
  parameter int NUM_SPRITES  = 128,
  parameter int COLOR_W      = 24,
  parameter int COORD_W      = 16,
  parameter int TILE_ID_W    = 7,
  parameter int PAL_SEL_W    = 1,
  parameter int RD_LAT       = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              vblank,
  output logic                              rw_color_palettes,
  output logic [$clog2(NUM_PALETTES)-1:0]   addr_color_palettes,
  input  logic [COLOR_W-1:0]                read_data_color_palettes,
  output logic                              rw_OAM,
  output logic [$clog2(2*NUM_SPRITES)-1:0]  addr_OAM,
  input  logic [31:0]                       read_data_OAM,
  input  logic [$clog2(NUM_SPRITES)-1:0]    sprite_sel,
  output logic [COORD_W-1:0]                sprite_x,
  output logic [COORD_W-1:0]                sprite_y,
  output logic [TILE_ID_W-1:0]              sprite_tile_id,
  output logic [PAL_SEL_W-1:0]              sprite_palette,
  output logic [1:0]                        sprite_rotation,
  input  logic [$clog2(NUM_PALETTES)-1:0]   pal_sel,
  output logic [COLOR_W-1:0]                pal_color,
  output logic                              load_busy,
  output logic                              load_done,
  output logic                              load_error,
  output logic                              frame_valid
);

  localparam int PAL_AW = $clog2(NUM_PALETTES);
  localparam int OAM_AW = $clog2(2*NUM_SPRITES);
  localparam int CNT_W  = (PAL_AW > OAM_AW) ? PAL_AW : OAM_AW;
`ifdef PPU_FRAME_LOADER_DOUBLE_BUFFER_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD_PAL, S_LOAD_OAM, S_DRAIN} state_t;

  // One in-flight RAM read: which RAM it targets and the entry/word index.
  typedef struct packed {
    logic             v;
    logic             oam;
    logic [CNT_W-1:0] idx;
  } rd_tag_t;

  state_t                 r_state, w_next;
  logic                   r_prev_vb;
  logic [CNT_W-1:0]       r_cnt;
  rd_tag_t [RD_LAT-1:0]   r_pipe;
  rd_tag_t                w_cap_tag;

  logic                   w_rise, w_trig, w_final, w_abort, w_cap, w_older_v;
  logic                   w_issue, w_issue_oam, w_last_issue;
  logic [CNT_W-1:0]       w_issue_idx;
  logic                   w_rd_bank, w_wr_bank;

  logic [NB-1:0][NUM_PALETTES-1:0][COLOR_W-1:0]  r_pal;
  logic [NB-1:0][NUM_SPRITES-1:0][COORD_W-1:0]   r_x, r_y;
  logic [NB-1:0][NUM_SPRITES-1:0][TILE_ID_W-1:0] r_tile;
  logic [NB-1:0][NUM_SPRITES-1:0][PAL_SEL_W-1:0] r_psel;
  logic [NB-1:0][NUM_SPRITES-1:0][1:0]           r_rot;

  // Event decode: trigger, final capture (pipe about to empty) and abort.
  always_comb begin
    w_older_v = 1'b0;
    for (int i = 0; i < RD_LAT-1; i++) w_older_v = w_older_v | r_pipe[i].v;
    w_cap_tag = r_pipe[RD_LAT-1];
    w_rise    = vblank & ~r_prev_vb;
    w_trig    = (r_state == S_IDLE) & w_rise;
    // Completion wins over vblank falling on the same edge.
    w_final   = (r_state == S_DRAIN) & w_cap_tag.v & ~w_older_v;
    w_abort   = (r_state != S_IDLE) & ~vblank & ~w_final;
    w_cap     = w_cap_tag.v & ~w_abort;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_rise) w_next = S_LOAD_PAL;
      S_LOAD_PAL: if (w_abort) w_next = S_IDLE;
                  else if (r_cnt == CNT_W'(NUM_PALETTES-1)) w_next = S_LOAD_OAM;
      S_LOAD_OAM: if (w_abort) w_next = S_IDLE;
                  else if (r_cnt == CNT_W'(2*NUM_SPRITES-1)) w_next = S_DRAIN;
      S_DRAIN:    if (w_final || w_abort) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // FSM outputs: which read (if any) is issued on this edge.
  always_comb begin
    rw_color_palettes = 1'b0;
    rw_OAM            = 1'b0;
    load_busy         = (r_state != S_IDLE);
    w_issue           = 1'b0;
    w_issue_oam       = 1'b0;
    w_issue_idx       = '0;
    case (r_state)
      S_IDLE:     w_issue = w_rise;
      S_LOAD_PAL: begin w_issue = ~w_abort; w_issue_idx = r_cnt; end
      S_LOAD_OAM: begin w_issue = ~w_abort; w_issue_oam = 1'b1; w_issue_idx = r_cnt; end
      default:    ;
    endcase
    w_last_issue = w_issue_oam ? (w_issue_idx == CNT_W'(2*NUM_SPRITES-1))
                               : (w_issue_idx == CNT_W'(NUM_PALETTES-1));
  end

  // Address counters, read-tag pipe, status pulses and frame_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prev_vb           <= 1'b0;
      r_cnt               <= '0;
      r_pipe              <= '0;
      addr_color_palettes <= '0;
      addr_OAM            <= '0;
      load_done           <= 1'b0;
      load_error          <= 1'b0;
      frame_valid         <= 1'b0;
    end else begin
      r_prev_vb           <= vblank;
      r_cnt               <= (w_issue && !w_last_issue) ? w_issue_idx + CNT_W'(1) : '0;
      addr_color_palettes <= (w_issue && !w_issue_oam) ? w_issue_idx[PAL_AW-1:0] : '0;
      addr_OAM            <= (w_issue &&  w_issue_oam) ? w_issue_idx[OAM_AW-1:0] : '0;
      if (w_abort) begin
        r_pipe <= '0;
      end else begin
        r_pipe[0] <= '{v: w_issue, oam: w_issue_oam, idx: w_issue_idx};
        for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
      load_done  <= w_final;
      load_error <= w_abort;
`ifdef PPU_FRAME_LOADER_DOUBLE_BUFFER_EN
      if (w_final) frame_valid <= 1'b1;
`else
      if (w_final)               frame_valid <= 1'b1;
      else if (w_trig || w_abort) frame_valid <= 1'b0;
`endif
    end
  end

`ifdef PPU_FRAME_LOADER_DOUBLE_BUFFER_EN
  logic r_front;
  assign w_rd_bank = r_front;
  assign w_wr_bank = ~r_front;

  // Swap banks once the back bank holds a complete frame.
  always_ff @(posedge clk) begin
    if (!reset)       r_front <= 1'b0;
    else if (w_final) r_front <= ~r_front;
  end
`else
  assign w_rd_bank = 1'b0;
  assign w_wr_bank = 1'b0;
`endif

  // Capture returning RAM data into the write bank, decoding OAM words.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pal  <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_tile <= '0;
      r_psel <= '0;
      r_rot  <= '0;
    end else if (w_cap) begin
      if (!w_cap_tag.oam) begin
        r_pal[w_wr_bank][w_cap_tag.idx[PAL_AW-1:0]] <= read_data_color_palettes;
      end else if (!w_cap_tag.idx[0]) begin
        r_tile[w_wr_bank][w_cap_tag.idx[OAM_AW-1:1]] <= read_data_OAM[TILE_ID_W-1:0];
        r_psel[w_wr_bank][w_cap_tag.idx[OAM_AW-1:1]] <= read_data_OAM[TILE_ID_W+PAL_SEL_W-1:TILE_ID_W];
        r_rot [w_wr_bank][w_cap_tag.idx[OAM_AW-1:1]] <= read_data_OAM[31:30];
      end else begin
        r_x[w_wr_bank][w_cap_tag.idx[OAM_AW-1:1]] <= read_data_OAM[COORD_W-1:0];
        r_y[w_wr_bank][w_cap_tag.idx[OAM_AW-1:1]] <= read_data_OAM[COORD_W+15:16];
      end
    end
  end

  assign sprite_x        = r_x   [w_rd_bank][sprite_sel];
  assign sprite_y        = r_y   [w_rd_bank][sprite_sel];
  assign sprite_tile_id  = r_tile[w_rd_bank][sprite_sel];
  assign sprite_palette  = r_psel[w_rd_bank][sprite_sel];
  assign sprite_rotation = r_rot [w_rd_bank][sprite_sel];
  assign pal_color       = r_pal [w_rd_bank][pal_sel];

endmodule

// File: doc/ppu_frame_loader.md
Name: ppu_frame_loader

Overview:
- Parametrised vblank-time attribute loader for the PPU.
- On each vblank rising edge it streams the colour palette RAM, then OAM, into local shadow registers.
- Sprite and palette attributes are exposed to the line renderer through indexed combinational read ports.
- Detects loads cut short by vblank ending and, optionally, double-buffers so the renderer never sees a half-loaded frame.

Parameters:
- NUM_PALETTES, 8, palette RAM entries (power of 2, >=2)
- NUM_SPRITES, 128, OAM sprites; each sprite is 2 OAM words (power of 2, >=2)
- COLOR_W, 24, palette entry width
- COORD_W, 16, sprite x/y width (<=16)
- TILE_ID_W, 7, tile id field width
- PAL_SEL_W, 1, sprite palette select width (TILE_ID_W+PAL_SEL_W <= 30)
- RD_LAT, 1, RAM read latency in cycles (1 or 2)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- vblank  in  1  vertical blank from the VGA timing block
- rw_color_palettes  out  1  palette RAM write enable; always 0 (read only)
- addr_color_palettes  out  $clog2(NUM_PALETTES)  palette RAM address
- read_data_color_palettes  in  COLOR_W  palette RAM data
- rw_OAM  out  1  OAM write enable; always 0
- addr_OAM  out  $clog2(2*NUM_SPRITES)  OAM word address
- read_data_OAM  in  32  OAM data
- sprite_sel  in  $clog2(NUM_SPRITES)  sprite query index
- sprite_x, sprite_y  out  COORD_W  x/y of sprite_sel
- sprite_tile_id  out  TILE_ID_W  tile id of sprite_sel
- sprite_palette  out  PAL_SEL_W  palette select of sprite_sel
- sprite_rotation  out  2  rotation of sprite_sel
- pal_sel  in  $clog2(NUM_PALETTES)  palette query index
- pal_color  out  COLOR_W  colour of pal_sel
- load_busy  out  1  load in progress
- load_done  out  1  one-cycle pulse when a load completes
- load_error  out  1  one-cycle pulse when a load is aborted
- frame_valid  out  1  front attribute set is a complete frame

Behaviour:
- Reset (reset=0 at an edge):
  - State IDLE; all counters 0.
  - Addresses 0, rw_* 0, load_busy/load_done/load_error/frame_valid 0.
  - All shadow registers 0; the prev-vblank register is 0.
  - Reset mid-load discards the load with no error pulse.
- States: IDLE, LOAD_PAL, LOAD_OAM, DRAIN.
- Trigger:
  - Edge T samples vblank=1 with prev_vblank=0. At T: state -> LOAD_PAL, addr_color_palettes=0, load_busy=1.
  - A vblank rising edge while busy is impossible; it is ignored.
- Read timing:
  - LOAD_PAL issues addresses 0..NUM_PALETTES-1, one per cycle.
  - Then LOAD_OAM issues words 0..2*NUM_SPRITES-1, one per cycle.
  - Data for an address issued at edge E is captured at edge E+RD_LAT, using a RD_LAT-deep pipe of {valid, kind, index}.
- OAM decode:
  - Even word 2i: tile_id=[TILE_ID_W-1:0], palette=[TILE_ID_W+PAL_SEL_W-1:TILE_ID_W], rotation=[31:30].
  - Odd word 2i+1: x=[COORD_W-1:0], y=[COORD_W+15:16].
- Issue to capture:
  - After the last OAM issue, state -> DRAIN; address outputs return to 0.
  - When the pipe empties, i.e. the final capture edge: load_done=1 for one cycle, load_busy=0, frame_valid=1, state -> IDLE.
  - Defaults: last issue at T+263, final capture at T+264, load_done high in the cycle after T+264.
- Abort:
  - vblank sampled 0 while load_busy=1: state -> IDLE, load_error=1 for one cycle, load_busy=0.
  - Captures are ignored from the abort edge onward.
  - Without double buffering, frame_valid=0 until the next complete load.
- Simultaneous events:
  - vblank falls on the final capture edge: the load counts as complete (load_done, no error).
  - Reset has priority over everything.
- Query ports are purely combinational from the front set, with zero-cycle latency.
- Out-of-range sel values cannot occur because widths are exact.

Optional Feature:
- Macro: PPU_FRAME_LOADER_DOUBLE_BUFFER_EN.
- Defined:
  - Two register banks. Captures write the back bank; query ports read the front bank.
  - On the load_done edge the banks swap; frame_valid is then set.
  - On abort there is no swap: front data and frame_valid are unchanged, and the back bank contents are don't-care.
- Undefined:
  - Single bank. Captures write the queried registers directly, so the renderer may see partial data during a load.
  - frame_valid=0 from the trigger edge until load_done.

Test Plan:
- Reset held 3 cycles, release, no vblank -> all outputs 0, addr_OAM=0, frame_valid=0.
- Palette RAM entry k = 0x100000*k+k, OAM word 2i = {2'b10,22'b0,1'b1,7'(i)}, word 2i+1 = {16'(i+200),16'(i+50)}; vblank rises and holds 300 cycles -> load_done pulse exactly 265 cycles after trigger; sprite_sel=5 gives x=55, y=205, tile=5, palette=1, rotation=2; pal_sel=3 gives 0x300003.
- vblank falls 100 cycles after trigger -> load_error pulse, no load_done. Double-buffer build: query ports keep the previous frame and frame_valid=1. Single-bank build: frame_valid=0.
- RD_LAT=2, same stimulus -> load_done 266 cycles after trigger; identical captured values.
- reset asserted at trigger+50, released, next vblank completes -> no load_error; load_done after the full 265 cycles; correct data.
- vblank falls exactly on the final capture edge -> load_done=1, load_error=0, frame_valid=1.
